// File: rtl/stream_route_xbar.sv
// stream_route_xbar: AXI-Stream broadcast crossbar with drain-and-swap route map; ROUTE_STATS_EN builds per-output beat counters
module stream_route_xbar #(
  parameter int NUM_IN = 5,
  parameter int NUM_OUT = 8,
  parameter int DATA_W = 1536,
  localparam int SEL_W = $clog2(NUM_IN + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_OUT*SEL_W-1:0]   ctrl,
  input  logic                       ctrl_load,
  output logic                       ctrl_busy,
  input  logic [NUM_IN*DATA_W-1:0]   s_tdata,
  input  logic [NUM_IN-1:0]          s_tvalid,
  output logic [NUM_IN-1:0]          s_tready,
  output logic [NUM_OUT*DATA_W-1:0]  m_tdata,
  output logic [NUM_OUT-1:0]         m_tvalid,
  input  logic [NUM_OUT-1:0]         m_tready,
  output logic [NUM_OUT*32-1:0]      stat_beats
);
  localparam logic [NUM_OUT*SEL_W-1:0] MAP_OFF = {NUM_OUT{SEL_W'(NUM_IN)}};
  typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;
  state_t state_q, state_d;
  logic [NUM_OUT*SEL_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic [NUM_OUT*DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic [NUM_OUT-1:0] m_tvalid_q, m_tvalid_d, can_acc;
  logic [NUM_IN-1:0] hit, blk;
  always_comb begin
    shadow_d = ctrl_load ? ctrl : shadow_q;
    state_d = state_q == RUN ? (ctrl_load ? DRAIN : RUN) :
              state_q == DRAIN ? (|m_tvalid_q ? DRAIN : SWAP) : RUN;
    active_d = state_q == SWAP ? shadow_d : active_q;
  end
  always_comb begin
    can_acc = ~m_tvalid_q | m_tready;
    hit = '0;
    blk = '0;
    for (int i = 0; i < NUM_IN; i++)
      for (int o = 0; o < NUM_OUT; o++)
        if (active_q[o*SEL_W +: SEL_W] == SEL_W'(i)) begin
          hit[i] = 1'b1;
          blk[i] = blk[i] | ~can_acc[o];
        end
    s_tready = state_q == RUN ? hit & ~blk : '0;
  end
  always_comb begin
    m_tvalid_d = m_tvalid_q & ~m_tready;
    m_tdata_d = m_tdata_q;
    for (int o = 0; o < NUM_OUT; o++)
      for (int i = 0; i < NUM_IN; i++)
        if (active_q[o*SEL_W +: SEL_W] == SEL_W'(i) && s_tvalid[i] && s_tready[i]) begin
          m_tvalid_d[o] = 1'b1;
          m_tdata_d[o*DATA_W +: DATA_W] = s_tdata[i*DATA_W +: DATA_W];
        end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      shadow_q <= MAP_OFF;
      active_q <= MAP_OFF;
      m_tvalid_q <= '0;
      m_tdata_q <= '0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q <= m_tdata_d;
    end
  end
  assign ctrl_busy = state_q != RUN;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata = m_tdata_q;
`ifdef ROUTE_STATS_EN
  logic [NUM_OUT*32-1:0] beats_q, beats_d;
  always_comb begin
    beats_d = beats_q;
    for (int o = 0; o < NUM_OUT; o++)
      if (m_tvalid_q[o] && m_tready[o]) beats_d[o*32 +: 32] = beats_q[o*32 +: 32] + 32'd1;
  end
  always_ff @(posedge clk) beats_q <= rst ? '0 : beats_d;
  assign stat_beats = beats_q;
`else
  assign stat_beats = '0;
`endif
endmodule

// File: tb/tb_stream_route_xbar.sv
// tb_stream_route_xbar: directed table and sequence checks of stream_route_xbar at NUM_IN=5, NUM_OUT=8, DATA_W=16
module tb_stream_route_xbar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] ctrl = '0;
  logic ctrl_load = 1'b0;
  logic ctrl_busy;
  logic [15:0] din = '0;
  logic [79:0] s_tdata;
  logic [4:0] s_tvalid = '0;
  logic [4:0] s_tready;
  logic [127:0] m_tdata;
  logic [7:0] m_tvalid;
  logic [7:0] m_tready = '0;
  logic [255:0] stat_beats;
  int checks = 0;
  int errors = 0;
  assign s_tdata = {5{din}};
  always #5 clk = ~clk;
  stream_route_xbar #(.NUM_IN(5), .NUM_OUT(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .ctrl_load(ctrl_load), .ctrl_busy(ctrl_busy),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .stat_beats(stat_beats)
  );
  typedef struct {
    logic ld;
    logic [23:0] ctl;
    logic [4:0] sv;
    logic [15:0] d;
    logic [7:0] mr;
    logic [7:0] e_mv;
    logic [4:0] e_sr;
    logic e_busy;
    logic [15:0] e_m0;
  } vec_t;
  vec_t tv[12];
  function automatic logic [23:0] map8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic load_map(input logic [23:0] m);
    ctrl = m;
    ctrl_load = 1'b1;
    cyc();
    ctrl_load = 1'b0;
    for (int n = 0; n < 20 && ctrl_busy; n++) cyc();
    chk("load_map_done", 32'(ctrl_busy), 32'd0);
  endtask
  logic [23:0] map_a;
  initial begin
    map_a = map8(0, 1, 2, 3, 4, 5, 5, 5);
    tv[0]  = '{1'b1, map_a, 5'h00, 16'h0000, 8'hFF, 8'h00, 5'h00, 1'b0, 16'h0000};
    tv[1]  = '{1'b0, map_a, 5'h01, 16'h1111, 8'hFF, 8'h00, 5'h00, 1'b1, 16'h0000};
    tv[2]  = '{1'b0, map_a, 5'h01, 16'h1111, 8'hFF, 8'h00, 5'h00, 1'b1, 16'h0000};
    tv[3]  = '{1'b0, map_a, 5'h01, 16'h1111, 8'hFF, 8'h00, 5'h1F, 1'b0, 16'h0000};
    tv[4]  = '{1'b0, map_a, 5'h00, 16'h0000, 8'hFF, 8'h01, 5'h1F, 1'b0, 16'h1111};
    tv[5]  = '{1'b0, map_a, 5'h00, 16'h0000, 8'h00, 8'h00, 5'h1F, 1'b0, 16'h1111};
    tv[6]  = '{1'b0, map_a, 5'h01, 16'h2222, 8'h00, 8'h00, 5'h1F, 1'b0, 16'h1111};
    tv[7]  = '{1'b0, map_a, 5'h01, 16'h3333, 8'h00, 8'h01, 5'h1E, 1'b0, 16'h2222};
    tv[8]  = '{1'b0, map_a, 5'h01, 16'h3333, 8'h00, 8'h01, 5'h1E, 1'b0, 16'h2222};
    tv[9]  = '{1'b0, map_a, 5'h01, 16'h3333, 8'h01, 8'h01, 5'h1F, 1'b0, 16'h2222};
    tv[10] = '{1'b0, map_a, 5'h00, 16'h0000, 8'h01, 8'h01, 5'h1F, 1'b0, 16'h3333};
    tv[11] = '{1'b0, map_a, 5'h00, 16'h0000, 8'hFF, 8'h00, 5'h1F, 1'b0, 16'h3333};
    cyc();
    cyc();
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_busy", 32'(ctrl_busy), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd0);
    chk("rst_mdata", 32'(|m_tdata), 32'd0);
    chk("rst_stat", 32'(|stat_beats), 32'd0);
    rst = 1'b0;
    cyc();
    for (int v = 0; v < 12; v++) begin
      ctrl_load = tv[v].ld;
      ctrl = tv[v].ctl;
      s_tvalid = tv[v].sv;
      din = tv[v].d;
      m_tready = tv[v].mr;
      #1;
      chk($sformatf("tv%0d_mvalid", v), 32'(m_tvalid), 32'(tv[v].e_mv));
      chk($sformatf("tv%0d_sready", v), 32'(s_tready), 32'(tv[v].e_sr));
      chk($sformatf("tv%0d_busy", v), 32'(ctrl_busy), 32'(tv[v].e_busy));
      chk($sformatf("tv%0d_m0", v), 32'(m_tdata[15:0]), 32'(tv[v].e_m0));
      cyc();
    end
    ctrl_load = 1'b0;
    s_tvalid = '0;
    m_tready = 8'hFF;
    load_map(map8(1, 1, 1, 5, 5, 5, 5, 5));
    s_tvalid = 5'h02;
    din = 16'hAAAA;
    m_tready = 8'hFD;
    #1;
    chk("bc_ready_empty", 32'(s_tready[1]), 32'd1);
    cyc();
    din = 16'hABCD;
    #1;
    chk("bc_first_mvalid", 32'(m_tvalid), 32'h07);
    chk("bc_blocked", 32'(s_tready[1]), 32'd0);
    cyc();
    chk("bc_hold_mvalid", 32'(m_tvalid), 32'h02);
    chk("bc_hold_o1", 32'(m_tdata[31:16]), 32'hAAAA);
    chk("bc_still_blocked", 32'(s_tready[1]), 32'd0);
    cyc();
    chk("bc_hold2_o1", 32'(m_tdata[31:16]), 32'hAAAA);
    m_tready = 8'hFF;
    #1;
    chk("bc_unblocked", 32'(s_tready[1]), 32'd1);
    cyc();
    s_tvalid = '0;
    #1;
    chk("bc_mvalid", 32'(m_tvalid), 32'h07);
    chk("bc_o0", 32'(m_tdata[15:0]), 32'hABCD);
    chk("bc_o1", 32'(m_tdata[31:16]), 32'hABCD);
    chk("bc_o2", 32'(m_tdata[47:32]), 32'hABCD);
    cyc();
    chk("bc_drained", 32'(m_tvalid), 32'h00);
    load_map(map8(5, 5, 5, 5, 5, 5, 2, 5));
    for (int k = 0; k <= 100; k++) begin
      s_tvalid = k < 100 ? 5'h04 : 5'h00;
      din = 16'(k + 16'h0100);
      #1;
      if (k > 0) chk($sformatf("stream_beat%0d", k - 1), {15'd0, m_tvalid[6], m_tdata[111:96]}, {15'd0, 1'b1, 16'(k - 1 + 16'h0100)});
      cyc();
    end
    chk("stream_drained", 32'(m_tvalid), 32'h00);
`ifdef ROUTE_STATS_EN
    chk("stream_stat_o6", stat_beats[223:192], 32'd100);
`else
    chk("stream_stat_o6", stat_beats[223:192], 32'd0);
`endif
    load_map(map8(5, 5, 5, 3, 5, 5, 5, 5));
    s_tvalid = 5'h08;
    din = 16'h3333;
    m_tready = 8'h00;
    cyc();
    s_tvalid = '0;
    ctrl = map8(3, 5, 5, 5, 5, 5, 5, 5);
    ctrl_load = 1'b1;
    cyc();
    ctrl_load = 1'b0;
    s_tvalid = 5'h1F;
    din = 16'h4444;
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("drain%0d_busy", n), 32'(ctrl_busy), 32'd1);
      chk($sformatf("drain%0d_sready", n), 32'(s_tready), 32'd0);
      chk($sformatf("drain%0d_mvalid", n), 32'(m_tvalid), 32'h08);
      cyc();
    end
    m_tready = 8'hFF;
    #1;
    chk("drain_last_sready", 32'(s_tready), 32'd0);
    cyc();
    chk("drain_empty_busy", 32'(ctrl_busy), 32'd1);
    chk("drain_empty_mvalid", 32'(m_tvalid), 32'h00);
    chk("drain_empty_sready", 32'(s_tready), 32'd0);
    cyc();
    chk("swap_busy", 32'(ctrl_busy), 32'd1);
    chk("swap_sready", 32'(s_tready), 32'd0);
    cyc();
    chk("newmap_busy", 32'(ctrl_busy), 32'd0);
    chk("newmap_sready", 32'(s_tready), 32'h08);
    cyc();
    s_tvalid = '0;
    #1;
    chk("newmap_mvalid", 32'(m_tvalid), 32'h01);
    chk("newmap_o0", 32'(m_tdata[15:0]), 32'h4444);
    cyc();
    s_tvalid = 5'h08;
    din = 16'h5555;
    m_tready = 8'h00;
    cyc();
    s_tvalid = '0;
    ctrl = map8(5, 4, 5, 5, 5, 5, 5, 5);
    ctrl_load = 1'b1;
    cyc();
    ctrl_load = 1'b0;
    chk("reload_busy1", 32'(ctrl_busy), 32'd1);
    cyc();
    ctrl = map8(5, 5, 1, 5, 5, 5, 5, 5);
    ctrl_load = 1'b1;
    cyc();
    ctrl_load = 1'b0;
    chk("reload_busy2", 32'(ctrl_busy), 32'd1);
    chk("reload_sready", 32'(s_tready), 32'd0);
    m_tready = 8'hFF;
    cyc();
    chk("reload_drained_busy", 32'(ctrl_busy), 32'd1);
    chk("reload_drained_mvalid", 32'(m_tvalid), 32'h00);
    cyc();
    chk("reload_swap_busy", 32'(ctrl_busy), 32'd1);
    cyc();
    chk("reload_run_busy", 32'(ctrl_busy), 32'd0);
    chk("reload_second_map", 32'(s_tready), 32'h02);
    s_tvalid = 5'h02;
    din = 16'h6666;
    m_tready = 8'h00;
    cyc();
    s_tvalid = '0;
    ctrl = map_a;
    ctrl_load = 1'b1;
    cyc();
    ctrl_load = 1'b0;
    chk("rstdrain_busy", 32'(ctrl_busy), 32'd1);
    chk("rstdrain_mvalid", 32'(m_tvalid), 32'h04);
    rst = 1'b1;
    cyc();
    chk("rstdrain_after_mvalid", 32'(m_tvalid), 32'h00);
    chk("rstdrain_after_busy", 32'(ctrl_busy), 32'd0);
    chk("rstdrain_after_sready", 32'(s_tready), 32'd0);
    chk("rstdrain_after_o2", 32'(m_tdata[47:32]), 32'h0000);
    chk("rstdrain_after_stat", 32'(|stat_beats), 32'd0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("rstdrain_no_pending_busy", 32'(ctrl_busy), 32'd0);
    chk("rstdrain_no_pending_sready", 32'(s_tready), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
